rr_demux_sel_arbiter: RTL
=========================

# rr_demux_sel_arbiter

- Round-robin arbiter and sequencer that sits directly upstream of the 1:8 demux.
- It arbitrates among 8 requesting channels and drives the demux's one-hot select code.
- It gates the serial data bit so only the granted channel's output can toggle.
- It inserts a break-before-make dead cycle between grants so the demux never sees overlapping or glitching selects.

## Interface
- BURST_LEN, 4, number of consecutive cycles a grant is held; legal range 1..16.
- i_clk  input  1  single clock; all state changes on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_req  input  8  per-channel request, level-sensitive; bit n requests channel n.
- i_a  input  1  serial data bit destined for the granted channel.
- o_sel_code  output  8  one-hot select to the demux; all-zero when no grant is active.
- o_a  output  1  data bit to the demux; equals i_a while a grant is active, else 0.
- o_busy  output  1  high while in GRANT.
- o_done  output  1  one-cycle pulse in the dead cycle following each grant.

## Operation
- Three states: IDLE, GRANT, RELEASE.
- Reset values: state IDLE, o_sel_code 8'h00, o_a 0, o_busy 0, o_done 0, burst counter 0, last-grant pointer ptr = 7.
- With ptr = 7 after reset, channel 0 has top priority.
- Arbitration:
  - Winner is the first set bit of i_req, searching upward from index ptr+1 with modulo-8 wrap.
  - Arbitration is evaluated in IDLE and RELEASE only.
  - On a win, ptr is set to the winner's index.
- IDLE:
  - If i_req == 0, stay in IDLE.
  - Otherwise move to GRANT with o_sel_code = 1 << winner and the counter cleared.
- GRANT:
  - o_sel_code is held constant and o_busy = 1.
  - The counter increments every cycle.
  - Move to RELEASE after BURST_LEN cycles in GRANT, or earlier if i_req[granted] is sampled low (early termination).
  - Requests from other channels never pre-empt the current grant.
- RELEASE: lasts exactly 1 cycle.
  - o_sel_code = 0, o_busy = 0, o_done = 1.
  - If i_req != 0, move to GRANT with the new winner; otherwise move to IDLE.
- o_a = i_a & o_busy. This path is combinational from i_a; all other outputs are registered.
- o_sel_code is always either one-hot or zero. Any other value is a design error.
- Reset asserted in any state forces the reset values on the next edge. An in-progress grant is dropped with no o_done pulse.

## Timing
- Request-to-grant latency:
  - A request sampled at edge k in IDLE gives o_sel_code valid after edge k.
  - That is 1 cycle from request assertion to the select appearing.
- Full grant occupies BURST_LEN cycles, then 1 RELEASE cycle.
- Back-to-back grants repeat every BURST_LEN+1 cycles, with exactly one all-zero select cycle between them.
- Early termination:
  - i_req[granted] sampled low at edge k means o_sel_code = 0 and o_done = 1 during the cycle after edge k.
  - The shortest possible grant is 1 cycle.
- BURST_LEN = 1: grant, release, grant, … with 50% duty per grant.
- A request deasserted in the same cycle the arbiter samples it is not granted.
- Simultaneous expiry and drop of the request is treated as one normal RELEASE (a single o_done pulse).

## Test plan
- Single request, BURST_LEN = 4:
  - Stimulus: reset, then i_req = 8'h08 held.
  - Required: o_sel_code = 8'h08 for 4 cycles, then 8'h00 with o_done = 1 for 1 cycle, repeating.
  - Required: o_a follows i_a only during the 8'h08 cycles.
- Full round robin:
  - Stimulus: i_req = 8'hFF from reset.
  - Required: grant order 01, 02, 04, …, 80, then 01 again (wrap 7→0).
  - Required: each grant lasts 4 cycles, separated by one zero cycle.
- Fairness across wrap:
  - Stimulus: i_req = 8'h81 after channel 7 was last granted.
  - Required: channel 0 is granted next, then channel 7, alternating.
- Early termination:
  - Stimulus: i_req = 8'h20, then clear bit 5 during the 2nd grant cycle.
  - Required: select drops to 8'h00 the following cycle with o_done = 1, then the block returns to IDLE.
- Reset mid-grant:
  - Stimulus: assert i_rst during the 3rd cycle of a grant to channel 2.
  - Required: all outputs are 0 after the edge and there is no o_done pulse.
  - Required: after release with i_req = 8'hFF, channel 0 is granted first.
- Data gating:
  - Stimulus: toggle i_a every cycle with i_req = 0.
  - Required: o_a stays 0 and o_sel_code stays 8'h00 throughout.

Source files
------------

// File: rtl/rr_demux_sel_arbiter_if.sv
// Handshake bundle between the round-robin arbiter and its requesters/demux.
// The arbiter takes the slave side; the requesting environment takes the master side.
interface rr_demux_sel_arbiter_if;
    logic [7:0] i_req;
    logic       i_a;
    logic [7:0] o_sel_code;
    logic       o_a;
    logic       o_busy;
    logic       o_done;

    modport master (
        output i_req,
        output i_a,
        input  o_sel_code,
        input  o_a,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_req,
        input  i_a,
        output o_sel_code,
        output o_a,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/rr_demux_sel_arbiter.sv
// Round-robin 8-channel arbiter driving a 1:8 demux one-hot select, with burst-limited
// grants, a break-before-make dead cycle between grants, and data gating.
module rr_demux_sel_arbiter #(
    parameter int unsigned BURST_LEN = 4
) (
    input logic                   i_clk,
    input logic                   i_rst,
    rr_demux_sel_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StRelease
    } state_e;

    localparam logic [4:0] LastCnt = 5'(BURST_LEN - 1);

    state_e     state_q;
    logic [2:0] ptr_q;
    logic [2:0] gnt_q;
    logic [4:0] cnt_q;
    logic [7:0] sel_q;
    logic       busy_q;
    logic       done_q;

    logic       win_valid;
    logic [2:0] win_idx;
    logic [2:0] scan_idx;
    logic       grant_last;

    // Scan from ptr+8 down to ptr+1 so the lowest offset above ptr wins last.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = ptr_q;
        scan_idx  = ptr_q;
        for (int k = 8; k >= 1; k--) begin
            scan_idx = ptr_q + 3'(k);
            if (bus.i_req[scan_idx]) begin
                win_valid = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign grant_last = (cnt_q == LastCnt) || !bus.i_req[gnt_q];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            ptr_q   <= 3'd7;
            gnt_q   <= 3'd0;
            cnt_q   <= 5'd0;
            sel_q   <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StRelease: begin
                    done_q <= 1'b0;
                    if (win_valid) begin
                        state_q <= StGrant;
                        sel_q   <= 8'b1 << win_idx;
                        gnt_q   <= win_idx;
                        ptr_q   <= win_idx;
                        cnt_q   <= 5'd0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StGrant: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (grant_last) begin
                        state_q <= StRelease;
                        sel_q   <= 8'h00;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    sel_q   <= 8'h00;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_sel_code = sel_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;
    // Only the data path is combinational so the demux sees i_a with no added latency.
    assign bus.o_a        = bus.i_a & busy_q;

endmodule
